// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and constants for the hazard-detection / forwarding controller.
// Stage tuples store destinations at a fixed maximum width so that the same
// type serves every REG_ADDR_W up to MAX_REG_ADDR_W; narrower indices are
// zero-extended on entry.
package hazard_pkg;

    localparam int MAX_REG_ADDR_W = 8;

    localparam logic [MAX_REG_ADDR_W-1:0] REG_ZERO = '0;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    typedef struct packed {
        logic                      valid;
        logic [MAX_REG_ADDR_W-1:0] dest;
        logic                      wb_en;
        logic                      mem_r;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '{valid: 1'b0, dest: REG_ZERO, wb_en: 1'b0, mem_r: 1'b0};

    // An entry only matters if it will really write a non-zero register.
    function automatic logic is_pending_writer(input stage_t s);
        return s.valid & s.wb_en & (s.dest != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_match.sv
// Per-operand comparator: tells whether one ID source operand depends on the
// destination of the EX, MEM or WB shadow entry.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  src_used,
    input  stage_t                ex_stage,
    input  stage_t                mem_stage,
    input  stage_t                wb_stage,
    output logic                  match_ex,
    output logic                  match_mem,
    output logic                  match_wb
);

    logic [MAX_REG_ADDR_W-1:0] src_ext;

    // The load flag is irrelevant for matching; the EX load flag is consumed
    // by the parent, where the stall and forwarding decisions are made.
    logic unused_load_bits;
    assign unused_load_bits = ^{ex_stage.mem_r, mem_stage.mem_r, wb_stage.mem_r};

    assign src_ext = MAX_REG_ADDR_W'(src);

    // Compare the operand against each pending writer; unread operands never match.
    always_comb begin
        match_ex  = src_used & is_pending_writer(ex_stage)  & (src_ext == ex_stage.dest);
        match_mem = src_used & is_pending_writer(mem_stage) & (src_ext == mem_stage.dest);
        match_wb  = src_used & is_pending_writer(wb_stage)  & (src_ext == wb_stage.dest);
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard-detection and forwarding controller for the 5-stage pipeline.
// Keeps a private shadow of the EX/MEM/WB destination tuples, raises a
// combinational stall for unresolvable dependencies, and registers the
// EXE-stage operand mux selects alongside the instruction entering EX.
// REG_ADDR_W must not exceed hazard_pkg::MAX_REG_ADDR_W.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W       = 5,
    parameter int NUM_SRC          = 2,
    parameter int RF_WRITE_THROUGH = 1,
    parameter int CNT_W            = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fwd_en,
    input  logic                          flush,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic [REG_ADDR_W-1:0]         id_dest,
    input  logic                          id_wb_en,
    input  logic                          id_mem_r_en,
    output logic                          stall,
    output logic [2*NUM_SRC-1:0]          fwd_sel,
    output logic [CNT_W-1:0]              stall_count
);

    stage_t ex_q;
    stage_t mem_q;
    stage_t wb_q;
    stage_t id_entry;

    logic [NUM_SRC-1:0]   m_ex;
    logic [NUM_SRC-1:0]   m_mem;
    logic [NUM_SRC-1:0]   m_wb;

    logic                 stall_int;
    logic                 advance;
    logic [2*NUM_SRC-1:0] fwd_next;
    logic [2*NUM_SRC-1:0] fwd_sel_q;
    logic [CNT_W-1:0]     stall_count_q;

    // One comparator per source operand.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_match
        hazard_match #(
            .REG_ADDR_W (REG_ADDR_W)
        ) u_match (
            .src       (id_src[g*REG_ADDR_W +: REG_ADDR_W]),
            .src_used  (id_src_used[g]),
            .ex_stage  (ex_q),
            .mem_stage (mem_q),
            .wb_stage  (wb_q),
            .match_ex  (m_ex[g]),
            .match_mem (m_mem[g]),
            .match_wb  (m_wb[g])
        );
    end

    // Stall only for a live, unsquashed ID instruction; forwarding mode leaves
    // load-use as the only hazard, stall-only mode waits for every writer.
    always_comb begin
        stall_int = 1'b0;
        if (rst && id_valid && !flush) begin
            if (fwd_en) begin
                stall_int = (|m_ex) & ex_q.mem_r;
            end else begin
                stall_int = |(m_ex | m_mem);
                if (RF_WRITE_THROUGH == 0) begin
                    stall_int = stall_int | (|m_wb);
                end
            end
        end
    end

    // Operand select for the instruction about to enter EX; the youngest
    // producer is checked first so it takes priority.
    always_comb begin
        fwd_next = '0;
        if (fwd_en) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (m_ex[k] && !ex_q.mem_r) begin
                    fwd_next[2*k +: 2] = FWD_MEM;
                end else if (m_mem[k]) begin
                    fwd_next[2*k +: 2] = FWD_WB;
                end else if ((RF_WRITE_THROUGH == 0) && m_wb[k]) begin
                    fwd_next[2*k +: 2] = FWD_WB;
                end else begin
                    fwd_next[2*k +: 2] = FWD_NONE;
                end
            end
        end
    end

    assign advance = id_valid & ~stall_int & ~flush;

    assign id_entry = '{valid: 1'b1,
                        dest:  MAX_REG_ADDR_W'(id_dest),
                        wb_en: id_wb_en,
                        mem_r: id_mem_r_en};

    // Shadow pipeline shift, registered forwarding selects and the saturating
    // stall counter; EX takes a bubble whenever ID does not advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q          <= STAGE_BUBBLE;
            mem_q         <= STAGE_BUBBLE;
            wb_q          <= STAGE_BUBBLE;
            fwd_sel_q     <= '0;
            stall_count_q <= '0;
        end else begin
            wb_q      <= mem_q;
            mem_q     <= ex_q;
            ex_q      <= advance ? id_entry : STAGE_BUBBLE;
            fwd_sel_q <= advance ? fwd_next : '0;
            if (stall_int && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
        end
    end

    assign stall       = stall_int;
    assign fwd_sel     = fwd_sel_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl. Two instances share every input:
// one with the default 16-bit stall counter, one with a 2-bit counter so
// saturation is reached by the accumulated stalls of the directed steps.
module tb_hazard_forward_ctrl;

    logic        clk;
    logic        rst;
    logic        fwd_en;
    logic        flush;
    logic        id_valid;
    logic [9:0]  id_src;
    logic [1:0]  id_src_used;
    logic [4:0]  id_dest;
    logic        id_wb_en;
    logic        id_mem_r_en;

    logic        stall_a;
    logic [3:0]  fwd_sel_a;
    logic [15:0] stall_count_a;
    logic        stall_b;
    logic [3:0]  fwd_sel_b;
    logic [1:0]  stall_count_b;

    typedef struct {
        string       tag;
        logic        stall;
        logic [3:0]  fwd;
        logic [15:0] cnt_a;
        logic [1:0]  cnt_b;
    } exp_t;

    exp_t        sb[$];
    int          compared;
    int          mismatched;
    logic [15:0] model_cnt_a;
    logic [1:0]  model_cnt_b;

    hazard_forward_ctrl #(
        .REG_ADDR_W (5), .NUM_SRC (2), .RF_WRITE_THROUGH (1), .CNT_W (16)
    ) dut_a (
        .clk (clk), .rst (rst), .fwd_en (fwd_en), .flush (flush),
        .id_valid (id_valid), .id_src (id_src), .id_src_used (id_src_used),
        .id_dest (id_dest), .id_wb_en (id_wb_en), .id_mem_r_en (id_mem_r_en),
        .stall (stall_a), .fwd_sel (fwd_sel_a), .stall_count (stall_count_a)
    );

    hazard_forward_ctrl #(
        .REG_ADDR_W (5), .NUM_SRC (2), .RF_WRITE_THROUGH (1), .CNT_W (2)
    ) dut_b (
        .clk (clk), .rst (rst), .fwd_en (fwd_en), .flush (flush),
        .id_valid (id_valid), .id_src (id_src), .id_src_used (id_src_used),
        .id_dest (id_dest), .id_wb_en (id_wb_en), .id_mem_r_en (id_mem_r_en),
        .stall (stall_b), .fwd_sel (fwd_sel_b), .stall_count (stall_count_b)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input string field,
                             input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s/%s observed=0x%0h expected=0x%0h", tag, field, obs, exp);
        end
    endtask

    // Drive one ID-stage cycle and queue what the DUTs must show for it.
    task automatic applyStimulus(input string tag, input logic r, input logic fe,
                                 input logic fl, input logic v,
                                 input logic [4:0] s1, input logic [4:0] s0,
                                 input logic [1:0] used, input logic [4:0] dest,
                                 input logic wb, input logic mr,
                                 input logic exp_stall, input logic [3:0] exp_fwd);
        exp_t e;
        rst         = r;
        fwd_en      = fe;
        flush       = fl;
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_dest     = dest;
        id_wb_en    = wb;
        id_mem_r_en = mr;
        if (!r) begin
            model_cnt_a = '0;
            model_cnt_b = '0;
        end else if (exp_stall) begin
            if (model_cnt_a != 16'hFFFF) model_cnt_a = model_cnt_a + 16'd1;
            if (model_cnt_b != 2'b11)    model_cnt_b = model_cnt_b + 2'd1;
        end
        e.tag   = tag;
        e.stall = exp_stall;
        e.fwd   = exp_fwd;
        e.cnt_a = model_cnt_a;
        e.cnt_b = model_cnt_b;
        sb.push_back(e);
    endtask

    // Sample the combinational stall mid-cycle, then the registered outputs
    // just after the edge, and compare against the queued expectation.
    task automatic checkOutput();
        exp_t e;
        logic obs_stall_a;
        logic obs_stall_b;
        #2;
        obs_stall_a = stall_a;
        obs_stall_b = stall_b;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            check_val(e.tag, "stall_a",     16'(obs_stall_a),   16'(e.stall));
            check_val(e.tag, "stall_b",     16'(obs_stall_b),   16'(e.stall));
            check_val(e.tag, "fwd_sel_a",   16'(fwd_sel_a),     16'(e.fwd));
            check_val(e.tag, "fwd_sel_b",   16'(fwd_sel_b),     16'(e.fwd));
            check_val(e.tag, "stall_cnt_a", stall_count_a,      e.cnt_a);
            check_val(e.tag, "stall_cnt_b", 16'(stall_count_b), 16'(e.cnt_b));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus("idle", 1, 1, 0, 0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0, 0, 4'h0);
            checkOutput();
        end
    endtask

    // Directed sequence of pipeline scenarios.
    initial begin
        compared    = 0;
        mismatched  = 0;
        model_cnt_a = '0;
        model_cnt_b = '0;

        applyStimulus("reset0", 0, 1, 0, 0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0, 0, 4'h0); checkOutput();
        applyStimulus("reset1", 0, 1, 0, 1, 5'd3, 5'd3, 2'b11, 5'd3, 1, 1, 0, 4'h0); checkOutput();

        // add r3 then sub reading r3: ALU forward from EX
        applyStimulus("alu_prod", 1, 1, 0, 1, 5'd2, 5'd1, 2'b11, 5'd3, 1, 0, 0, 4'h0); checkOutput();
        applyStimulus("alu_cons", 1, 1, 0, 1, 5'd6, 5'd3, 2'b11, 5'd4, 1, 0, 0, 4'b0001); checkOutput();
        idle(3);

        // Two producers at different distances feeding both operands
        applyStimulus("two_p1", 1, 1, 0, 1, 5'd2, 5'd1, 2'b11, 5'd8, 1, 0, 0, 4'h0); checkOutput();
        applyStimulus("two_p2", 1, 1, 0, 1, 5'd2, 5'd1, 2'b11, 5'd9, 1, 0, 0, 4'h0); checkOutput();
        applyStimulus("two_c",  1, 1, 0, 1, 5'd9, 5'd8, 2'b11, 5'd2, 1, 0, 0, 4'b0110); checkOutput();
        idle(3);

        // Same register written twice: youngest producer wins
        applyStimulus("young_p1", 1, 1, 0, 1, 5'd2, 5'd1, 2'b11, 5'd10, 1, 0, 0, 4'h0); checkOutput();
        applyStimulus("young_p2", 1, 1, 0, 1, 5'd2, 5'd1, 2'b11, 5'd10, 1, 0, 0, 4'h0); checkOutput();
        applyStimulus("young_c",  1, 1, 0, 1, 5'd1, 5'd10, 2'b11, 5'd11, 1, 0, 0, 4'b0001); checkOutput();
        idle(3);

        // Load-use on operand 1: one stall, then WB forward
        applyStimulus("lu_load",  1, 1, 0, 1, 5'd0, 5'd1, 2'b01, 5'd5, 1, 1, 0, 4'h0); checkOutput();
        applyStimulus("lu_stall", 1, 1, 0, 1, 5'd5, 5'd1, 2'b11, 5'd6, 1, 0, 1, 4'h0); checkOutput();
        applyStimulus("lu_go",    1, 1, 0, 1, 5'd5, 5'd1, 2'b11, 5'd6, 1, 0, 0, 4'b1000); checkOutput();
        idle(3);

        // Stall-only mode: two stall cycles until the producer reaches WB
        applyStimulus("so_prod", 1, 0, 0, 1, 5'd2, 5'd1, 2'b11, 5'd7, 1, 0, 0, 4'h0); checkOutput();
        applyStimulus("so_st1",  1, 0, 0, 1, 5'd1, 5'd7, 2'b11, 5'd8, 1, 0, 1, 4'h0); checkOutput();
        applyStimulus("so_st2",  1, 0, 0, 1, 5'd1, 5'd7, 2'b11, 5'd8, 1, 0, 1, 4'h0); checkOutput();
        applyStimulus("so_go",   1, 0, 0, 1, 5'd1, 5'd7, 2'b11, 5'd8, 1, 0, 0, 4'h0); checkOutput();
        idle(3);

        // Load into r0 never hazards; an unread operand never hazards
        applyStimulus("r0_load", 1, 1, 0, 1, 5'd0, 5'd1, 2'b01, 5'd0, 1, 1, 0, 4'h0); checkOutput();
        applyStimulus("r0_cons", 1, 1, 0, 1, 5'd0, 5'd0, 2'b11, 5'd12, 1, 0, 0, 4'h0); checkOutput();
        applyStimulus("un_load", 1, 1, 0, 1, 5'd0, 5'd1, 2'b01, 5'd11, 1, 1, 0, 4'h0); checkOutput();
        applyStimulus("un_cons", 1, 1, 0, 1, 5'd11, 5'd1, 2'b01, 5'd12, 0, 0, 0, 4'h0); checkOutput();
        idle(3);

        // Flush over a load-use hazard: no stall, bubble enters EX
        applyStimulus("fl_load", 1, 1, 0, 1, 5'd0, 5'd1, 2'b01, 5'd5, 1, 1, 0, 4'h0); checkOutput();
        applyStimulus("fl_sq",   1, 1, 1, 1, 5'd5, 5'd1, 2'b11, 5'd9, 1, 0, 0, 4'h0); checkOutput();
        applyStimulus("fl_next", 1, 1, 0, 1, 5'd5, 5'd9, 2'b11, 5'd13, 1, 0, 0, 4'b1000); checkOutput();
        idle(3);

        // More stall-only hazards drive the 2-bit counter into saturation
        applyStimulus("sat_p1", 1, 0, 0, 1, 5'd2, 5'd1, 2'b11, 5'd7, 1, 0, 0, 4'h0); checkOutput();
        applyStimulus("sat_s1", 1, 0, 0, 1, 5'd1, 5'd7, 2'b11, 5'd8, 1, 0, 1, 4'h0); checkOutput();
        applyStimulus("sat_s2", 1, 0, 0, 1, 5'd1, 5'd7, 2'b11, 5'd8, 1, 0, 1, 4'h0); checkOutput();
        applyStimulus("sat_g1", 1, 0, 0, 1, 5'd1, 5'd7, 2'b11, 5'd8, 1, 0, 0, 4'h0); checkOutput();
        applyStimulus("sat_p2", 1, 0, 0, 1, 5'd2, 5'd1, 2'b11, 5'd14, 1, 0, 0, 4'h0); checkOutput();
        applyStimulus("sat_s3", 1, 0, 0, 1, 5'd1, 5'd14, 2'b11, 5'd15, 1, 0, 1, 4'h0); checkOutput();
        applyStimulus("sat_s4", 1, 0, 0, 1, 5'd1, 5'd14, 2'b11, 5'd15, 1, 0, 1, 4'h0); checkOutput();
        applyStimulus("sat_g2", 1, 0, 0, 1, 5'd1, 5'd14, 2'b11, 5'd15, 1, 0, 0, 4'h0); checkOutput();
        idle(3);

        // Reset in the middle of a stall clears everything
        applyStimulus("rs_prod", 1, 0, 0, 1, 5'd2, 5'd1, 2'b11, 5'd7, 1, 0, 0, 4'h0); checkOutput();
        applyStimulus("rs_st",   1, 0, 0, 1, 5'd1, 5'd7, 2'b11, 5'd8, 1, 0, 1, 4'h0); checkOutput();
        applyStimulus("rs_low",  0, 0, 0, 1, 5'd1, 5'd7, 2'b11, 5'd8, 1, 0, 0, 4'h0); checkOutput();
        applyStimulus("rs_after",1, 0, 0, 1, 5'd1, 5'd7, 2'b11, 5'd8, 1, 0, 0, 4'h0); checkOutput();
        idle(3);

        // fwd_en toggling: stall reacts the same cycle, fwd_sel on the next update
        applyStimulus("fe_prod", 1, 1, 0, 1, 5'd2, 5'd1, 2'b11, 5'd20, 1, 0, 0, 4'h0); checkOutput();
        applyStimulus("fe_off",  1, 0, 0, 1, 5'd1, 5'd20, 2'b11, 5'd21, 1, 0, 1, 4'h0); checkOutput();
        applyStimulus("fe_on",   1, 1, 0, 1, 5'd1, 5'd20, 2'b11, 5'd21, 1, 0, 0, 4'b0010); checkOutput();
        idle(2);

        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Parametrised, self-contained hazard-detection and forwarding controller for the 5-stage MIPS pipeline.
- It is the successor to the inline hazard/forwarding logic in the pipeline top.
- It keeps its own shadow copy of the EXE/MEM/WB destination tuples, so the top no longer routes stage registers into it.
- It supports N source operands, runtime forwarding on/off, and optional write-back-stage hazards for non-write-through register files.
- It also counts stall cycles.
- Sits beside the ID stage; drives the IF/ID/EXE-register stall and the EXE-stage operand muxes.

Parameters:
- REG_ADDR_W, 5, register index width; register 0 is hardwired zero and never hazards.
- NUM_SRC, 2, number of source operands checked per instruction (1..4).
- RF_WRITE_THROUGH, 1, 1 = register file returns same-cycle write data, so WB never hazards; 0 = WB-stage match also stalls or forwards.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- fwd_en  in  1  1 = forwarding mode; 0 = stall-only mode.
- flush  in  1  branch taken; the ID instruction is squashed.
- id_valid  in  1  ID stage holds a real instruction.
- id_src  in  NUM_SRC*REG_ADDR_W  packed source register indices; operand k is at bits [k*REG_ADDR_W +: REG_ADDR_W].
- id_src_used  in  NUM_SRC  per-operand "actually read" flag (cleared for an immediate operand 2).
- id_dest  in  REG_ADDR_W  destination register of the ID instruction.
- id_wb_en  in  1  ID instruction writes back.
- id_mem_r_en  in  1  ID instruction is a load.
- stall  out  1  combinational; freeze PC, IF/ID and ID/EXE, and insert a bubble.
- fwd_sel  out  2*NUM_SRC  registered, aligned to the EXE stage; per operand: 00 register file, 01 MEM-stage ALU result, 10 WB data, 11 unused.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Shadow pipeline: three entries EX, MEM, WB, each holding {valid, dest, wb_en, mem_r}.
  - A "pending writer" is an entry with valid & wb_en & dest != 0.
- Each clock with rst=1 the entries shift WB<-MEM<-EX. EX loads one of:
  - the ID tuple, if id_valid & ~stall & ~flush;
  - otherwise a bubble (valid=0).
  - MEM and WB always advance; the pipeline never freezes past ID.
- Match(k, S) = id_src_used[k] & id_src[k] == S.dest & S is a pending writer.
- Stall rules, evaluated only when id_valid & ~flush (otherwise stall=0):
  - fwd_en=1: stall = OR over k of Match(k, EX) & EX.mem_r (load-use hazard only).
  - fwd_en=0: stall = OR over k of Match(k, EX) | Match(k, MEM), plus Match(k, WB) when RF_WRITE_THROUGH=0.
- Load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM, so the consumer forwards from WB (10).
- fwd_sel, registered when the ID instruction advances into EX (otherwise cleared to 0):
  - applies only when fwd_en=1;
  - per operand k: Match(k, EX) & ~EX.mem_r gives 01; else Match(k, MEM) gives 10; else, when RF_WRITE_THROUGH=0, Match(k, WB) gives 10 (data captured via the WB path); else 00;
  - the youngest producer wins;
  - fwd_en=0 always gives 00.
- stall_count increments on every cycle stall=1 and saturates at all-ones; no wrap.
- Simultaneous flush & hazard: flush wins, stall=0, bubble enters EX.
- Reset (rst=0 at a clock edge), including mid-stall:
  - all entries set to valid=0;
  - fwd_sel=0 and stall_count=0;
  - stall is forced 0 while rst=0.
- An fwd_en change takes effect on the same cycle for stall and on the next register update for fwd_sel.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - the stage-tuple typedef {valid, dest, wb_en, mem_r};
  - a REG_ZERO constant.
- One natural sub-module, hazard_match: per-operand comparator producing the match vector against the EX, MEM and WB entries. It is instantiated NUM_SRC times via generate.

Test Plan:
- Dependent ALU op: fwd_en=1, issue add r3 then sub using r3 as src0 → stall=0; fwd_sel[1:0]=01 in the sub's EXE cycle.
- Load-use: fwd_en=1, lw r5 followed by an op with src1=r5 → stall=1 for exactly 1 cycle, then fwd_sel[3:2]=10; stall_count=1.
- Stall-only mode: fwd_en=0, add r7 then an op reading r7 → stall=1 for 2 cycles (RF_WRITE_THROUGH=1), fwd_sel=0, stall_count=2.
- Zero register and unused operand: producer writes r0, or the consumer has id_src_used[1]=0 with a matching index → stall=0, fwd_sel=00.
- Flush during load-use: hazard present and flush=1 → stall=0 and a bubble in EX; the following cycle shows EX.valid=0.
- Reset and saturation: with CNT_W=2, hold the hazard for 5 cycles → stall_count=3; then rst=0 for 1 edge → stall_count=0, fwd_sel=0, stall=0.
